// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with glitch-free ratio change and start/stop.
// Odd ratios optionally get a true 50% duty cycle through a falling-edge copy of the high phase.
module prog_clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter bit DUTY50      = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             pend_valid,
    output logic             err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_act_q, n_act_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             odd_q, odd_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   half;
    logic [WIDTH-1:0] cnt_inc;
    logic             boundary, load_ok, take_pend;

    assign half     = ({1'b0, n_act_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    assign cnt_inc  = cnt_q + 1'b1;
    assign boundary = (cnt_q == n_act_q - 1'b1);
    assign load_ok  = div_load && (div_val >= WIDTH'(2));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_act_d      = n_act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        pos_d        = 1'b0;
        odd_d        = odd_q;
        tick_d       = 1'b0;
        err_d        = div_load && !load_ok;
        take_pend    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    pos_d     = 1'b1;
                    tick_d    = 1'b1;
                    take_pend = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_d     = '0;
                    take_pend = 1'b1;
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        pos_d  = 1'b1;
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = ({1'b0, cnt_inc} < half);
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_pend && pend_valid_q) begin
            n_act_d      = pend_q;
            pend_valid_d = 1'b0;
        end
        if (load_ok) begin
            pend_d       = div_val;
            pend_valid_d = 1'b1;
        end

        // The duty-mode select only moves while clk_out is low and settling: every
        // idle cycle, or on the edge into the last (low) cycle of a running period.
        if ((state_q == IDLE && !en) ||
            (state_q == RUN && !boundary && cnt_inc == n_act_q - 1'b1))
            odd_d = pend_valid_d ? pend_d[0] : n_act_d[0];
    end

    assign neg_d = pos_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_act_q      <= WIDTH'(DEFAULT_DIV);
            pend_q       <= WIDTH'(DEFAULT_DIV);
            pend_valid_q <= 1'b0;
            pos_q        <= 1'b0;
            odd_q        <= 1'(DEFAULT_DIV % 2);
            tick_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_act_q      <= n_act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            pos_q        <= pos_d;
            odd_q        <= odd_d;
            tick_q       <= tick_d;
            err_q        <= err_d;
        end
    end

    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= neg_d;
    end

    // Masking with the half-cycle-late copy trims the odd high phase to exactly N/2.
    assign clk_out    = (DUTY50 && odd_q) ? (pos_q & neg_q) : pos_q;
    assign tick       = tick_q;
    assign busy       = (state_q == RUN);
    assign pend_valid = pend_valid_q;
    assign err        = err_q;

endmodule
